// File: rtl/io_display_driver_pkg.sv
// Shared definitions for the display driver: FSM states, active-high
// seven-segment codes ({g,f,e,d,c,b,a}) and the double-dabble nibble helper.
package io_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_FORMAT  = 2'd2
  } state_t;

  // Segment codes, active-high. Output polarity is applied once at the
  // hex output register, so everything inside works in this form.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  // Shift/add-3 correction: a BCD nibble of 5 or more would become >= 10
  // after the next doubling, so it is pre-biased by 3.
  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/io_display_driver_seg7_encoder.sv
// Combinational BCD digit to active-high seven-segment pattern.
// Non-decimal codes map to a blank digit.
module io_display_driver_seg7_encoder
  import io_display_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Decode one BCD nibble to its segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/io_display_driver.sv
// Display driver for the IO unit's magnitude/sign output. Converts the
// magnitude to BCD one bit per cycle, then formats all digits in a single
// cycle (leading-zero blanking, minus placement, overflow 'E') and updates
// the hex outputs atomically. Updates arriving while busy are parked in a
// pending slot (last one wins) and converted right after the current one.
module io_display_driver
  import io_display_driver_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGITS     = 8,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  update,
  input  logic [WIDTH-1:0]      value,
  input  logic                  negative,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7*DIGITS-1:0] HEX_BLANK =
    SEG_ACT_LO ? {(7*DIGITS){1'b1}} : {(7*DIGITS){1'b0}};

  state_t                   state_r;
  logic [WIDTH-1:0]         shift_r;
  logic [BCD_W-1:0]         bcd_r;
  logic                     sign_r;
  logic                     ovf_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     pending_r;
  logic [WIDTH-1:0]         pend_value_r;
  logic                     pend_neg_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     overflow_r;
  logic [7*DIGITS-1:0]      hex_r;

  logic [BCD_W-1:0]         bcd_adj_s;
  logic [DIGITS-1:0][6:0]   digit_seg_s;
  logic [DIGITS-1:0][6:0]   fmt_seg_s;
  logic [7*DIGITS-1:0]      fmt_hex_s;
  logic                     fmt_ovf_s;
  logic                     nonzero_s;
  int                       msd_s;

  // Per-digit segment decoders, fed straight from the BCD register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    io_display_driver_seg7_encoder u_enc (
      .bcd (bcd_r[4*g +: 4]),
      .seg (digit_seg_s[g])
    );
  end

  // Add-3 correction of every BCD nibble ahead of the next shift.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[4*i +: 4] = add3_nibble(bcd_r[4*i +: 4]);
    end
  end

  // Locate the most significant nonzero digit (0 when the value is zero).
  always_comb begin
    msd_s = 0;
    for (int i = 0; i < DIGITS; i++) begin
      msd_s = (bcd_r[4*i +: 4] != 4'd0) ? i : msd_s;
    end
    nonzero_s = |bcd_r;
  end

  // Build the complete display image: digits, blanking, sign or 'E'.
  always_comb begin
    // A negative number that already uses every digit has no room for the sign.
    fmt_ovf_s = ovf_r | (sign_r & nonzero_s & (msd_s == DIGITS - 1));
    fmt_seg_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (fmt_ovf_s) begin
        fmt_seg_s[i] = (i == 0) ? SEG_E : SEG_BLANK;
      end else if (i <= msd_s) begin
        fmt_seg_s[i] = digit_seg_s[i];
      end else if (sign_r && nonzero_s && (i == msd_s + 1)) begin
        fmt_seg_s[i] = SEG_MINUS;
      end else begin
        fmt_seg_s[i] = SEG_BLANK;
      end
    end
    fmt_hex_s = SEG_ACT_LO ? ~fmt_seg_s : fmt_seg_s;
  end

  // Control FSM: load, bit-serial conversion, format, pending handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      bcd_r        <= '0;
      sign_r       <= 1'b0;
      ovf_r        <= 1'b0;
      cnt_r        <= '0;
      pending_r    <= 1'b0;
      pend_value_r <= '0;
      pend_neg_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      hex_r        <= HEX_BLANK;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            // Restart from the parked request; a same-cycle update re-parks.
            shift_r <= pend_value_r;
            bcd_r   <= '0;
            sign_r  <= pend_neg_r;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_CONVERT;
            if (update) begin
              pend_value_r <= value;
              pend_neg_r   <= negative;
              pending_r    <= 1'b1;
            end else begin
              pending_r <= 1'b0;
            end
          end else if (update) begin
            shift_r <= value;
            bcd_r   <= '0;
            sign_r  <= negative;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_CONVERT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[WIDTH-1]};
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          ovf_r   <= ovf_r | bcd_adj_s[BCD_W-1];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            state_r <= ST_FORMAT;
          end else begin
            state_r <= ST_CONVERT;
          end
          if (update) begin
            pend_value_r <= value;
            pend_neg_r   <= negative;
            pending_r    <= 1'b1;
          end
        end
        ST_FORMAT: begin
          hex_r      <= fmt_hex_s;
          overflow_r <= fmt_ovf_s;
          done_r     <= 1'b1;
          // Stay busy across the handoff when another request is waiting.
          busy_r     <= pending_r | update;
          state_r    <= ST_IDLE;
          if (update) begin
            pend_value_r <= value;
            pend_neg_r   <= negative;
            pending_r    <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;
  assign hex_out  = hex_r;

endmodule

// File: tb/tb_io_display_driver.sv
// Directed self-checking bench for io_display_driver (default parameters,
// active-low segments). Expected hex images are hand-built from the
// segment table: digit codes active-low 0..9 =
// 40,79,24,30,19,12,02,78,00,10; minus 3F; 'E' 06; blank 7F.
module tb_io_display_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic [31:0] value = 32'd0;
  logic        negative = 1'b0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [55:0] hex_out;

  int tests = 0;
  int fails = 0;

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

  io_display_driver #(
    .WIDTH      (32),
    .DIGITS     (8),
    .SEG_ACT_LO (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .update   (update),
    .value    (value),
    .negative (negative),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex_out  (hex_out)
  );

  always #5 clk = ~clk;

  // Present one update strobe; returns #1 after the sampling edge E.
  task automatic pulse_update(input logic [31:0] v, input logic n);
    @(negedge clk);
    value = v;
    negative = n;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges after E at which done is seen.
  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (hex_out !== ALL_BLANK) begin fails++; $display("FAIL reset_hex: got %h expected %h", hex_out, ALL_BLANK); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (hex_out !== ALL_BLANK) begin fails++; $display("FAIL idle_hex: got %h expected %h", hex_out, ALL_BLANK); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_busy_done: got %b%b expected 00", busy, done); end
  endtask

  task automatic test_basic();
    logic [55:0] exp_hex;
    int bad_k;
    exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    pulse_update(32'd1234, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
    bad_k = 0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (bad_k == 0 && (busy !== (k < 33) || done !== (k == 33))) begin
        bad_k = k;
        $display("FAIL basic_timing: at E+%0d busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, (k < 33), (k == 33));
      end
    end
    tests++; if (bad_k != 0) fails++;
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL basic_hex: got %h expected %h", hex_out, exp_hex); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (hex_out !== exp_hex || done !== 1'b0) begin fails++; $display("FAIL basic_hold: got %h/%b expected %h/0", hex_out, done, exp_hex); end
  endtask

  task automatic test_negative();
    logic [55:0] exp_hex;
    int lat;
    exp_hex = {7'h7F, 7'h7F, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00};
    pulse_update(32'd32768, 1'b1);
    wait_done("neg32768", lat);
    tests++; if (lat != 33) begin fails++; $display("FAIL neg_latency: got %0d expected 33", lat); end
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL neg_hex: got %h expected %h", hex_out, exp_hex); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL neg_overflow: got %b expected 0", overflow); end
    exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    pulse_update(32'd0, 1'b1);
    wait_done("negzero", lat);
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL negzero_hex: got %h expected %h", hex_out, exp_hex); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL negzero_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [55:0] exp_hex;
    int lat;
    exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06};
    pulse_update(32'd100000000, 1'b0);
    wait_done("ovf_big", lat);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_big_flag: got %b expected 1", overflow); end
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL ovf_big_hex: got %h expected %h", hex_out, exp_hex); end
    pulse_update(32'd12345678, 1'b1);
    wait_done("ovf_sign", lat);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sign_flag: got %b expected 1", overflow); end
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL ovf_sign_hex: got %h expected %h", hex_out, exp_hex); end
    exp_hex = {8{7'h10}};
    pulse_update(32'd99999999, 1'b0);
    wait_done("max8", lat);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL max8_flag: got %b expected 0", overflow); end
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL max8_hex: got %h expected %h", hex_out, exp_hex); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] exp5;
    logic [55:0] exp7;
    int n_done;
    int bad_busy;
    exp5 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12};
    exp7 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    n_done = 0;
    bad_busy = 0;
    pulse_update(32'd5, 1'b0);
    for (int k = 1; k <= 75; k++) begin
      if (k == 5) begin
        value = 32'd6; negative = 1'b0; update = 1'b1;
      end else if (k == 10) begin
        value = 32'd7; negative = 1'b0; update = 1'b1;
      end else begin
        update = 1'b0;
      end
      @(posedge clk);
      #1;
      update = 1'b0;
      if (k <= 66 && busy !== 1'b1 && bad_busy == 0) begin
        bad_busy = k;
        $display("FAIL b2b_busy: at E+%0d got %b expected 1", k, busy);
      end
      if (done === 1'b1) begin
        n_done++;
        tests++;
        if (k == 33) begin
          if (hex_out !== exp5) begin fails++; $display("FAIL b2b_first_hex: got %h expected %h", hex_out, exp5); end
        end else if (k == 67) begin
          if (hex_out !== exp7) begin fails++; $display("FAIL b2b_second_hex: got %h expected %h", hex_out, exp7); end
        end else begin
          fails++;
          $display("FAIL b2b_done_time: done at E+%0d expected E+33 or E+67", k);
        end
      end
    end
    tests++; if (bad_busy != 0) fails++;
    tests++; if (n_done != 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_repeat();
    int lat;
    pulse_update(32'd7, 1'b0);
    wait_done("repeat", lat);
    tests++; if (lat != 33) begin fails++; $display("FAIL repeat_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_reset_mid();
    logic [55:0] exp_hex;
    int n_done;
    int lat;
    exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
    n_done = 0;
    pulse_update(32'd4321, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (hex_out !== ALL_BLANK) begin fails++; $display("FAIL midrst_hex: got %h expected %h", hex_out, ALL_BLANK); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL midrst_flags: got %b%b%b expected 000", busy, done, overflow); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    tests++; if (n_done != 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n_done); end
    pulse_update(32'd42, 1'b0);
    wait_done("after_rst", lat);
    tests++; if (lat != 33) begin fails++; $display("FAIL after_rst_latency: got %0d expected 33", lat); end
    tests++; if (hex_out !== exp_hex) begin fails++; $display("FAIL after_rst_hex: got %h expected %h", hex_out, exp_hex); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_repeat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
